// File: rtl/signal_capture_if.sv
// signal_capture_if
// Purpose : groups the sample input, trigger control and replay stream of
//           signal_capture into one bundle.
// Signals : din/din_valid        filtered sample stream (signed) into the capture
//           arm/trig_level       capture start pulse and signed trigger threshold
//           busy/triggered       capture status
//           dout/dout_valid/     replay stream out of the capture buffer
//           dout_ready/dout_last
//           done                 one-cycle pulse after the final replay transfer
//           state_dbg            raw FSM state for observation
// Modports: slave  - the capture block
//           master - the environment driving samples and consuming replay
//
// Replay handshake: a sample moves when dout_valid & dout_ready are both high
// on a rising edge. Once dout_valid is raised, dout, dout_valid and dout_last
// stay unchanged until that transfer happens; dout_valid never depends
// combinationally on dout_ready.
interface signal_capture_if #(
  parameter int DATA_W = 12
) ();
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              arm;
  logic [DATA_W-1:0] trig_level;
  logic              busy;
  logic              triggered;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              done;
  logic [2:0]        state_dbg;

  modport slave (
    input  din, din_valid, arm, trig_level, dout_ready,
    output busy, triggered, dout, dout_valid, dout_last, done, state_dbg
  );

  modport master (
    output din, din_valid, arm, trig_level, dout_ready,
    input  busy, triggered, dout, dout_valid, dout_last, done, state_dbg
  );
endinterface

// File: rtl/signal_capture.sv
// signal_capture
// Purpose : records a filtered sample stream into a circular RAM with a
//           pre-trigger window and a rising level-crossing trigger, then
//           replays the DEPTH-sample record in chronological order as a
//           valid/ready stream.
// Ports   : sys_clk    - single clock, rising edge
//           sys_rst_n  - asynchronous active-low reset
//           bus        - signal_capture_if.slave (samples, arm/level, status,
//                        replay stream, done pulse, debug state)
// Parameters: DATA_W   sample width (two's complement)
//             ADDR_W   buffer address width, DEPTH = 2**ADDR_W
//             PRE_TRIG samples kept ahead of the trigger sample, 1..DEPTH-2
module signal_capture #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 8,
  parameter int PRE_TRIG = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  signal_capture_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0]   PRE_LAST  = (ADDR_W+1)'(PRE_TRIG - 1);
  localparam logic [ADDR_W:0]   POST_LAST = (ADDR_W+1)'(DEPTH - PRE_TRIG - 1);
  localparam logic [ADDR_W:0]   RD_LAST   = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   RD_TOTAL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PRE_OFFS  = ADDR_W'(PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic signed [DATA_W-1:0] r_lvl;
  logic signed [DATA_W-1:0] r_prev;
  logic                     r_prev_ok;
  logic [ADDR_W-1:0]        r_wr_ptr;
  logic [ADDR_W-1:0]        r_start_ptr;
  logic [ADDR_W-1:0]        r_rd_ptr;
  // Phase counter: writes in PRE, writes since trigger in POST, reads issued in READ.
  logic [ADDR_W:0]          r_cnt;
  logic                     r_triggered;
  logic                     r_done;

  // Replay pipeline: RAM output register (stage 1) feeding the dout register.
  logic [DATA_W-1:0]        r_ram_q;
  logic                     r_s1_valid;
  logic                     r_s1_last;
  logic [DATA_W-1:0]        r_dout;
  logic                     r_dout_valid;
  logic                     r_dout_last;

  logic signed [DATA_W-1:0] w_sample;
  logic                     w_capturing;
  logic                     w_wr_en;
  logic                     w_cross;
  logic                     w_trig;
  logic                     w_out_free;
  logic                     w_s1_adv;
  logic                     w_issue;
  logic                     w_final;

  assign w_sample    = $signed(bus.din);
  assign w_capturing = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_wr_en     = w_capturing && bus.din_valid;
  // Rising crossing needs a genuine previous sample below the level; a signal
  // already above the level at arm time never fires on its own.
  assign w_cross     = r_prev_ok && (r_prev < r_lvl) && (w_sample >= r_lvl);
  assign w_trig      = (r_state == S_ARMED) && bus.din_valid && w_cross;

  // The dout register can take new data when it is empty or being drained.
  assign w_out_free  = !r_dout_valid || bus.dout_ready;
  assign w_s1_adv    = r_s1_valid && w_out_free;
  // A RAM read is issued only when stage 1 will have room for its result, so
  // nothing is overwritten while the output is stalled.
  assign w_issue     = (r_state == S_READ) && (r_cnt != RD_TOTAL) &&
                       (!r_s1_valid || w_out_free);
  assign w_final     = r_dout_valid && bus.dout_ready && r_dout_last;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.arm) w_next = S_PRE;
      S_PRE:   if (bus.din_valid && (r_cnt == PRE_LAST)) w_next = S_ARMED;
      S_ARMED: if (w_trig) w_next = S_POST;
      S_POST:  if (bus.din_valid && (r_cnt == POST_LAST)) w_next = S_READ;
      S_READ:  if (w_final) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture bookkeeping, trigger and replay pipeline
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_lvl        <= '0;
      r_prev       <= '0;
      r_prev_ok    <= 1'b0;
      r_wr_ptr     <= '0;
      r_start_ptr  <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_triggered  <= 1'b0;
      r_done       <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
    end else begin
      r_done <= w_final;

      if (w_wr_en) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_prev    <= w_sample;
        r_prev_ok <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.arm) begin
            r_lvl     <= $signed(bus.trig_level);
            r_wr_ptr  <= '0;
            r_cnt     <= '0;
            r_prev_ok <= 1'b0;
          end
        end
        S_PRE: begin
          if (bus.din_valid) r_cnt <= r_cnt + 1'b1;
        end
        S_ARMED: begin
          if (w_trig) begin
            // The trigger sample itself counts as the first post sample.
            r_cnt       <= (ADDR_W+1)'(1);
            r_start_ptr <= r_wr_ptr - PRE_OFFS;
            r_triggered <= 1'b1;
          end
        end
        S_POST: begin
          if (bus.din_valid) begin
            if (r_cnt == POST_LAST) begin
              r_cnt    <= '0;
              r_rd_ptr <= r_start_ptr;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_cnt    <= r_cnt + 1'b1;
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
          if (w_final) r_triggered <= 1'b0;
        end
        default: ;
      endcase

      if (w_issue) begin
        r_s1_valid <= 1'b1;
        r_s1_last  <= (r_cnt == RD_LAST);
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_out_free) begin
        r_dout_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_dout      <= r_ram_q;
          r_dout_last <= r_s1_last;
        end else begin
          r_dout_last <= 1'b0;
        end
      end
    end
  end

  // Sample buffer: synchronous write and registered read, no reset.
  always_ff @(posedge sys_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= bus.din;
    if (w_issue) r_ram_q <= r_mem[r_rd_ptr];
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.triggered  = r_triggered;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout_last  = r_dout_last;
  assign bus.done       = r_done;
  assign bus.state_dbg  = r_state;

endmodule
